// File: rtl/demux_collect_if.sv
// Handshake bundle for demux_collect.
//   in_valid/in_ready/in_data   : serial sample stream into the collector
//   out_valid/out_ready/out_vec : completed DIM-entry vectors out of the collector
// modport slave  : collector side
// modport master : producer/consumer side
interface demux_collect_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIM   = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_vec [DIM];

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_vec
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/demux_collect.sv
// Serial-to-parallel collector with ping-pong banks.
// Each accepted signed sample is steered into slot wr_idx of the bank being
// written; a completed bank is presented as one parallel vector on out_vec.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   clr      : synchronous clear, same effect as rst
//   bus      : demux_collect_if.slave (serial input, vector output)
//   wr_idx   : slot the next accepted sample fills
//   full_cnt : completed banks awaiting read (0..2)
module demux_collect #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIM       = 8,
  parameter int unsigned SEL_WIDTH = $clog2(DIM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  demux_collect_if.slave       bus,
  output logic [SEL_WIDTH-1:0] wr_idx,
  output logic [1:0]           full_cnt
);

  localparam int unsigned NBANK = 2;

  logic signed [WIDTH-1:0] bank_q [NBANK][DIM];
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [SEL_WIDTH-1:0]    wr_idx_q, wr_idx_d;
  logic [NBANK-1:0]        full_q, full_d;

  logic in_ready_c;
  logic out_valid_c;
  logic accept;
  logic consume;
  logic last_slot;

  // Handshake decode; ready/valid depend on registered flags only.
  assign in_ready_c  = ~full_q[wr_bank_q];
  assign out_valid_c = full_q[rd_bank_q];
  assign accept      = bus.in_valid & in_ready_c;
  assign consume     = out_valid_c & bus.out_ready;
  assign last_slot   = (wr_idx_q == SEL_WIDTH'(DIM - 1));

  // Next-state for pointers and full flags.
  // accept needs full[wr_bank]=0 and consume needs full[rd_bank]=1, so the
  // two never target the same bank in one cycle.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    if (accept) begin
      if (last_slot) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + SEL_WIDTH'(1);
      end
    end
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State and bank storage; clr behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      full_q    <= '0;
      for (int b = 0; b < NBANK; b++) begin
        for (int k = 0; k < DIM; k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      if (accept) begin
        bank_q[wr_bank_q][wr_idx_q] <= bus.in_data;
      end
    end
  end

  // Vector output comes straight from the read bank's registers.
  for (genvar k = 0; k < DIM; k++) begin : g_out
    assign bus.out_vec[k] = bank_q[rd_bank_q][k];
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign wr_idx        = wr_idx_q;
  assign full_cnt      = 2'(full_q[0]) + 2'(full_q[1]);

endmodule
